// File: rtl/prog_downcounter_if.sv
// Control and status bundle for prog_downcounter; the timing consumer drives the controls.
// Combinational wiring only, no flow control of its own.
interface prog_downcounter_if #(
   parameter int WIDTH = 17
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] period_in;
   logic [1:0]       mode_in;
   logic             zero;
   logic             wave;
   logic             done;
   logic [WIDTH-1:0] value;

   modport master (
      output enable, load, period_in, mode_in,
      input  zero, wave, done, value
   );

   modport slave (
      input  enable, load, period_in, mode_in,
      output zero, wave, done, value
   );
endinterface

// File: rtl/prog_downcounter.sv
// Run-time programmable down counter: periodic pulse, one-shot or 50% square, optional prescaler.
// zero/wave/done are registered one clk after the expiring tick; no backpressure, enable freezes.
module prog_downcounter #(
   parameter int WIDTH          = 17,
   parameter int DEFAULT_PERIOD = 100000,
   parameter int PRESCALE       = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   prog_downcounter_if.slave  bus
);
   localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_RELOAD = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] DEF_PER  = WIDTH'(DEFAULT_PERIOD);

   typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [1:0]       mode_q, mode_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             zero_q, zero_d;
   logic             wave_q, wave_d;
   logic             done_q, done_d;

   logic             tick;
   logic             expire;
   logic             one_shot;
   logic             square;
   logic [WIDTH-1:0] load_per;

   assign tick     = bus.enable && (pre_q == '0);
   assign expire   = (state_q == ST_RUN) && tick && (count_q == '0);
   assign one_shot = (mode_q == 2'b01);
   assign square   = (mode_q == 2'b10);
   // A programmed period of 0 behaves as 1.
   assign load_per = (bus.period_in == '0) ? WIDTH'(1) : bus.period_in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_RUN;
         count_q  <= '0;
         period_q <= DEF_PER;
         mode_q   <= 2'b00;
         pre_q    <= '0;
         zero_q   <= 1'b0;
         wave_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         pre_q    <= pre_d;
         zero_q   <= zero_d;
         wave_q   <= wave_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.load) begin
         state_d = ST_RUN;
      end else if (expire && one_shot) begin
         state_d = ST_DONE;
      end
   end

   // Load takes priority over any tick in the same cycle, so an expiry it collides with is dropped.
   always_comb begin
      count_d  = count_q;
      period_d = period_q;
      mode_d   = mode_q;
      pre_d    = pre_q;
      zero_d   = 1'b0;
      wave_d   = wave_q;
      done_d   = done_q;
      if (bus.load) begin
         period_d = load_per;
         mode_d   = bus.mode_in;
         count_d  = load_per - 1'b1;
         pre_d    = PRE_RELOAD;
         wave_d   = 1'b0;
         done_d   = 1'b0;
      end else begin
         if (bus.enable) begin
            pre_d = (pre_q == '0) ? PRE_RELOAD : pre_q - 1'b1;
         end
         if ((state_q == ST_RUN) && tick) begin
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               zero_d = 1'b1;
               if (one_shot) begin
                  count_d = '0;
                  done_d  = 1'b1;
               end else begin
                  count_d = period_q - 1'b1;
                  if (square) begin
                     wave_d = ~wave_q;
                  end
               end
            end
         end
      end
   end

   assign bus.zero  = zero_q;
   assign bus.wave  = wave_q;
   assign bus.done  = done_q;
   assign bus.value = count_q;
endmodule

// File: tb/tb_prog_downcounter.sv
// Scoreboard bench for prog_downcounter: two instances (no prescale / prescale 3), directed vectors.
module tb_prog_downcounter;
   localparam int W = 17;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic samp_req = 1'b0;

   always #5 clk = ~clk;

   prog_downcounter_if #(.WIDTH(W)) ia ();
   prog_downcounter_if #(.WIDTH(W)) ib ();

   prog_downcounter #(.WIDTH(W), .DEFAULT_PERIOD(5), .PRESCALE(1)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ia)
   );

   prog_downcounter #(.WIDTH(W), .DEFAULT_PERIOD(5), .PRESCALE(3)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ib)
   );

   typedef struct {
      bit           sel;
      logic         z;
      logic         w;
      logic         d;
      logic [W-1:0] v;
   } exp_t;

   exp_t  q[$];
   string tq[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   task automatic expect_out(input bit sel, input logic z, input logic w, input logic d,
                             input logic [W-1:0] v, input string tag);
      exp_t e;
      e.sel = sel; e.z = z; e.w = w; e.d = d; e.v = v;
      q.push_back(e);
      tq.push_back(tag);
   endtask

   // Drive one cycle of stimulus; expected outputs refer to the state after the next rising edge.
   task automatic step(input bit sel, input logic en, input logic ld, input logic [W-1:0] per,
                       input logic [1:0] md, input logic z, input logic w, input logic d,
                       input logic [W-1:0] v, input string tag);
      @(negedge clk);
      if (!sel) begin
         ia.enable = en; ia.load = ld; ia.period_in = per; ia.mode_in = md;
      end else begin
         ib.enable = en; ib.load = ld; ib.period_in = per; ib.mode_in = md;
      end
      expect_out(sel, z, w, d, v, tag);
   endtask

   // Compare between clock edges (used for reset checks).
   task automatic sample_now(input bit sel, input logic [W-1:0] v, input string tag);
      expect_out(sel, 1'b0, 1'b0, 1'b0, v, tag);
      samp_req = 1'b1;
      #1 samp_req = 1'b0;
      #1;
   endtask

   exp_t         m_e;
   string        m_tag;
   logic [W+2:0] m_act;
   logic [W+2:0] m_want;

   initial begin
      forever begin
         @(posedge clk or posedge samp_req);
         #1;
         if (q.size() > 0) begin
            m_e    = q.pop_front();
            m_tag  = tq.pop_front();
            m_act  = m_e.sel ? {ib.zero, ib.wave, ib.done, ib.value}
                             : {ia.zero, ia.wave, ia.done, ia.value};
            m_want = {m_e.z, m_e.w, m_e.d, m_e.v};
            n_chk++;
            if (m_act === m_want) begin
               n_pass++;
            end else begin
               $display("FAIL %s @%0t: got zero=%b wave=%b done=%b value=%0d, want zero=%b wave=%b done=%b value=%0d",
                        m_tag, $time, m_act[W+2], m_act[W+1], m_act[W], m_act[W-1:0],
                        m_want[W+2], m_want[W+1], m_want[W], m_want[W-1:0]);
            end
         end
      end
   end

   initial begin
      ia.enable = 0; ia.load = 0; ia.period_in = '0; ia.mode_in = 2'b00;
      ib.enable = 0; ib.load = 0; ib.period_in = '0; ib.mode_in = 2'b00;
      repeat (2) @(negedge clk);
      sample_now(0, '0, "reset_a");
      sample_now(1, '0, "reset_b");
      reset_n = 1'b1;

      // Default period 5: first tick expires immediately, then 4,3,2,1,0.
      for (int k = 1; k <= 11; k++)
         step(0, 1, 0, '0, 2'b00, ((k - 1) % 5) == 0, 0, 0, W'(4 - ((k - 1) % 5)), "periodic_def");

      // One-shot, period 3.
      step(0, 1, 1, W'(3), 2'b01, 0, 0, 0, W'(2), "oneshot_load");
      step(0, 1, 0, '0, 2'b00, 0, 0, 0, W'(1), "oneshot_cnt");
      step(0, 1, 0, '0, 2'b00, 0, 0, 0, W'(0), "oneshot_cnt");
      step(0, 1, 0, '0, 2'b00, 1, 0, 1, W'(0), "oneshot_fire");
      for (int k = 0; k < 20; k++)
         step(0, 1, 0, '0, 2'b00, 0, 0, 1, W'(0), "oneshot_hold");

      // Square, period 4: load clears done, wave toggles every 4 ticks.
      step(0, 1, 1, W'(4), 2'b10, 0, 0, 0, W'(3), "square_load");
      for (int k = 1; k <= 19; k++)
         step(0, 1, 0, '0, 2'b00, (k % 4) == 0, ((k / 4) % 2) == 1, 0, W'(3 - (k % 4)), "square");

      // count is 0 here: the load collides with the expiring tick.
      step(0, 1, 1, W'(2), 2'b00, 0, 0, 0, W'(1), "load_vs_expire");
      step(0, 1, 0, '0, 2'b00, 0, 0, 0, W'(0), "period2");
      step(0, 1, 0, '0, 2'b00, 1, 0, 0, W'(1), "period2_fire");
      step(0, 1, 1, W'(0), 2'b00, 0, 0, 0, W'(0), "load_zero");
      for (int k = 0; k < 4; k++)
         step(0, 1, 0, '0, 2'b00, 1, 0, 0, W'(0), "period1");

      // Load accepted with enable low, then async reset right after a square toggle.
      step(0, 0, 1, W'(6), 2'b10, 0, 0, 0, W'(5), "load_no_enable");
      for (int k = 1; k <= 6; k++)
         step(0, 1, 0, '0, 2'b00, k == 6, k == 6, 0, W'((k == 6) ? 5 : 5 - k), "square6");
      @(posedge clk);
      #3;
      reset_n   = 1'b0;
      ia.enable = 1'b0;
      sample_now(0, '0, "async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 1, 0, '0, 2'b00, 1, 0, 0, W'(4), "post_reset");
      step(0, 1, 0, '0, 2'b00, 0, 0, 0, W'(3), "post_reset");

      // Prescale 3, period 2: zero every 6 clks; 7 disabled clks delay it by 7.
      step(1, 1, 1, W'(2), 2'b00, 0, 0, 0, W'(1), "ps_load");
      for (int k = 1; k <= 12; k++)
         step(1, 1, 0, '0, 2'b00, (k % 6) == 0, 0, 0,
              W'(((k % 6) == 0 || (k % 6) == 1 || (k % 6) == 2) ? 1 : 0), "ps_periodic");
      step(1, 1, 0, '0, 2'b00, 0, 0, 0, W'(1), "ps_pre");
      for (int k = 0; k < 7; k++)
         step(1, 0, 0, '0, 2'b00, 0, 0, 0, W'(1), "ps_frozen");
      step(1, 1, 0, '0, 2'b00, 0, 0, 0, W'(1), "ps_resume");
      step(1, 1, 0, '0, 2'b00, 0, 0, 0, W'(0), "ps_resume");
      step(1, 1, 0, '0, 2'b00, 0, 0, 0, W'(0), "ps_resume");
      step(1, 1, 0, '0, 2'b00, 0, 0, 0, W'(0), "ps_resume");
      step(1, 1, 0, '0, 2'b00, 1, 0, 0, W'(1), "ps_delayed_fire");

      @(negedge clk);
      ia.enable = 0; ib.enable = 0;
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         $display("FAIL drain: %0d expected responses never compared, want 0", q.size());
         n_chk += q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/prog_downcounter.md
Name: prog_downcounter

Overview:
Runtime-programmable successor to the fixed-period downcounter. It is parametrised in width and has an optional built-in prescaler. Period and mode are loaded at run time, and it supports three modes: periodic pulse, one-shot, and 50% square wave. It sits in the clocking/timing layer and drives display refresh, debounce sampling and PWM-style enables; the zero output stays cascade-compatible.

Parameters:
WIDTH, 17, bit width of count, period register and value output (must cover max period - 1).
DEFAULT_PERIOD, 100000, period register value after reset (must be >= 1 and < 2^WIDTH).
PRESCALE, 1, internal pre-divider; count advances once per PRESCALE enabled clocks (1 = no prescale).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  active-high count enable (feeds prescaler)
load  input  1  one-clk strobe: latch period_in and mode_in, restart count
period_in  input  WIDTH  new period (0 is treated as 1)
mode_in  input  2  00 periodic, 01 one-shot, 10 square, 11 treated as periodic
zero  output  1  one-clk pulse when count expires
wave  output  1  square-wave output (mode 10 only; else held 0)
done  output  1  one-shot finished flag
value  output  WIDTH  current count

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - count = 0, period_reg = DEFAULT_PERIOD, mode_reg = 00, prescale count = 0, state = RUN.
  - zero = 0, wave = 0, done = 0, value = 0.
  - The first tick after reset therefore pulses zero, matching legacy downcounter behaviour.
- Tick:
  - tick = enable AND (prescale count == 0).
  - Each enabled clk, the prescale count reloads PRESCALE-1 at 0, otherwise decrements.
  - Prescale is frozen when enable = 0.
  - With PRESCALE = 1, tick = enable.
- States: RUN, DONE.
  - RUN, tick, count != 0: count decrements; zero <= 0.
  - RUN, tick, count == 0:
    - zero <= 1 for exactly one clk (registered, visible the cycle after the expiring edge).
    - Periodic: count <= period_reg-1, stay RUN.
    - Square: count <= period_reg-1, wave toggles, stay RUN.
    - One-shot: count held 0, done <= 1, go to DONE.
  - RUN, no tick: count holds; zero <= 0.
  - DONE: count held 0, zero = 0, done = 1; ticks are ignored. Only load or reset exits DONE.
- Load:
  - On load, period_reg <= max(period_in, 1) and mode_reg <= mode_in.
  - count <= max(period_in, 1) - 1; prescale count <= PRESCALE-1.
  - zero <= 0, done <= 0, wave <= 0, state <= RUN.
- Load priority: load wins over a simultaneous tick, so no zero pulse occurs in that cycle. Load is accepted regardless of enable.
- Period rules:
  - Periodic: zero pulses every period_reg ticks.
  - Square: wave period = 2*period_reg ticks, 50% duty.
  - One-shot: zero pulses once, period_reg ticks after load.
  - period_reg = 1 gives zero high on every tick. With continuous enable and PRESCALE = 1, zero stays high continuously.
- Arithmetic: unsigned WIDTH bits. No wrap-around below 0, because reload occurs at 0. The upper bits of period_in above WIDTH do not exist (port width = WIDTH).
- Mid-operation events:
  - Reset mid-count returns all state to reset values immediately (asynchronous).
  - Deasserting enable freezes count and prescaler exactly; zero drops to 0 on the next clk.
- value = count register, combinational from the register.

Test Plan:
- Reset, then enable = 1, no load, with DEFAULT_PERIOD = 5 and PRESCALE = 1 -> zero pulses in clk 1 after reset, then every 5 clks. value cycles 4,3,2,1,0.
- load period_in = 3, mode_in = 01, enable = 1 -> value 2,1,0. A single zero pulse occurs 3 ticks after load, done = 1 and stays 1 for 20 further clks with no more pulses. A new load clears done.
- load period_in = 4, mode_in = 10, enable = 1 -> wave toggles every 4 clks (8-clk period, 4 high / 4 low). zero pulses at each toggle.
- PRESCALE = 3, period 2, periodic, enable = 1 -> zero pulses every 6 clks. Dropping enable for 7 clks mid-count delays the next pulse by exactly 7 clks.
- Load asserted in the same clk as an expiring tick (count = 0) -> no zero pulse that cycle, and count = new period-1 next cycle. load period_in = 0 -> behaves as period 1.
- Assert reset_n = 0 asynchronously mid-count in square mode -> wave, zero, done, value go to 0 immediately (before the next clk edge), and period_reg returns to DEFAULT_PERIOD.
